fx2_fifo_arbiter: RTL

FX2_FIFO_ARBITER -- requirements
Module: fx2_fifo_arbiter

---
 rtl/fx2_pkg.sv | 9 +
 rtl/fx2_skid_reg.sv | 19 +
 rtl/fx2_fifo_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/fx2_pkg.sv
// fx2_pkg: shared FSM states and default parameters for the FX2 slave-FIFO arbiter
package fx2_pkg;
  typedef enum logic [2:0] {IDLE, OUT_SETUP, OUT_READ, IN_SETUP, IN_WRITE, IN_PKTEND} state_t;
  localparam logic [1:0] IN_FIFOADR_D = 2'b00;
  localparam logic [1:0] OUT_FIFOADR_D = 2'b10;
  localparam int BURST_LEN_D = 16;
  localparam int PKT_SIZE_D = 512;
  localparam int TIMEOUT_D = 1024;
endpackage

// File: rtl/fx2_skid_reg.sv
// fx2_skid_reg: one-deep holding register for bytes read from the OUT endpoint
module fx2_skid_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid
);
  always_ff @(posedge clk)
    if (rst) begin
      o_data <= '0;
      o_valid <= 1'b0;
    end else begin
      o_data <= i_load ? i_data : o_data;
      o_valid <= i_load || (o_valid && !i_ready);
    end
endmodule

// File: rtl/fx2_fifo_arbiter.sv
// fx2_fifo_arbiter: FX2 slave-FIFO arbiter, OUT reads have priority over IN writes.
// Define FX2_PKTEND_TIMEOUT_EN to flush partial IN packets with pktend after an idle timeout.
module fx2_fifo_arbiter
  import fx2_pkg::*;
#(
  parameter logic [1:0] IN_FIFOADR = IN_FIFOADR_D,
  parameter logic [1:0] OUT_FIFOADR = OUT_FIFOADR_D,
  parameter int BURST_LEN = BURST_LEN_D,
  parameter int PKT_SIZE = PKT_SIZE_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic       ifclk,
  input  logic       reset,
  output logic [1:0] fifoadr,
  input  logic [7:0] fd_in,
  output logic [7:0] fd_out,
  output logic       fd_oe,
  output logic       slrd,
  output logic       slwr,
  output logic       pktend,
  input  logic       in_full,
  input  logic       out_empty,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int PW = $clog2(PKT_SIZE);
  state_t r_state, w_next;
  logic [BW-1:0] r_burst;
  logic [PW-1:0] r_pkt_cnt;
  logic [1:0] r_fifoadr;
  logic w_last, w_flush, w_flush_go;
  // strobes are gated by reset so a byte offered during reset is never taken
  assign slrd = !reset && r_state == OUT_READ && !out_empty && (!cmd_valid || cmd_ready);
  assign slwr = !reset && r_state == IN_WRITE && src_valid && !in_full;
  assign src_ready = slwr;
  assign fd_out = src_data;
  assign fd_oe = r_state inside {IN_SETUP, IN_WRITE, IN_PKTEND};
  assign fifoadr = r_fifoadr;
  assign w_last = r_burst == BW'(BURST_LEN - 1);
`ifdef FX2_PKTEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle;
  logic r_flush, w_idle_ok;
  assign w_idle_ok = r_state == IDLE && r_pkt_cnt != '0 && !src_valid && out_empty;
  assign w_flush_go = w_idle_ok && r_idle == TW'(TIMEOUT);
  assign w_flush = r_flush;
  assign pktend = !reset && r_state == IN_PKTEND;
  always_ff @(posedge ifclk)
    if (reset) begin
      r_idle <= '0;
      r_flush <= 1'b0;
    end else begin
      r_idle <= (w_idle_ok && !w_flush_go) ? r_idle + 1'b1 : '0;
      r_flush <= (r_state == IDLE) ? w_flush_go : r_flush;
    end
`else
  assign w_flush_go = 1'b0;
  assign w_flush = 1'b0;
  assign pktend = 1'b0;
`endif
  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE:      w_next = !out_empty ? OUT_SETUP : ((src_valid && !in_full) || w_flush_go) ? IN_SETUP : IDLE;
      OUT_SETUP: w_next = OUT_READ;
      OUT_READ:  w_next = (out_empty || (slrd && w_last)) ? IDLE : OUT_READ;
      IN_SETUP:  w_next = w_flush ? IN_PKTEND : IN_WRITE;
      IN_WRITE:  w_next = (!slwr || w_last) ? IDLE : IN_WRITE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge ifclk)
    if (reset) begin
      r_state <= IDLE;
      r_fifoadr <= OUT_FIFOADR;
      r_burst <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_fifoadr <= (r_state != IDLE) ? r_fifoadr : (w_next == OUT_SETUP) ? OUT_FIFOADR : (w_next == IN_SETUP) ? IN_FIFOADR : r_fifoadr;
      r_burst <= (slrd || slwr) ? r_burst + 1'b1 : (r_state inside {OUT_READ, IN_WRITE}) ? r_burst : '0;
      r_pkt_cnt <= pktend ? '0 : slwr ? r_pkt_cnt + 1'b1 : r_pkt_cnt;
    end
  fx2_skid_reg u_cmd (
    .clk    (ifclk),
    .rst    (reset),
    .i_load (slrd),
    .i_data (fd_in),
    .i_ready(cmd_ready),
    .o_data (cmd_data),
    .o_valid(cmd_valid)
  );
endmodule
